// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the 3-bit sequence counter family.
//   - code constants for the sequence 0 -> 5 -> 7 -> 6 -> 3 -> 2 -> 0
//   - checker state encoding (HUNT / LOCKED)
//   - seq_succ():  successor lookup (illegal codes map to 0)
//   - seq_legal(): legality test (codes 1 and 4 are illegal)
package seq_pkg;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd5;
  localparam logic [2:0] S2 = 3'd7;
  localparam logic [2:0] S3 = 3'd6;
  localparam logic [2:0] S4 = 3'd3;
  localparam logic [2:0] S5 = 3'd2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic seq_legal(input logic [2:0] q);
    return (q != 3'd1) && (q != 3'd4);
  endfunction

  function automatic logic [2:0] seq_succ(input logic [2:0] q);
    logic [2:0] s;
    case (q)
      S0:      s = S1;
      S1:      s = S2;
      S2:      s = S3;
      S3:      s = S4;
      S4:      s = S5;
      S5:      s = S0;
      default: s = S0;  // illegal codes have no successor
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_next_lut.sv
// seq_next_lut: combinational next-code lookup for the sequence counter.
//   q     in  3  current code
//   legal out 1  q is a code of the sequence (not 1 or 4)
//   succ  out 3  successor of q (0 when q is illegal)
module seq_next_lut
  import seq_pkg::*;
(
  input  logic [2:0] q,
  output logic       legal,
  output logic [2:0] succ
);

  assign legal = seq_legal(q);
  assign succ  = seq_succ(q);

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: watches a 3-bit sequence counter, locks after a run of
// correct transitions, then flags out-of-sequence and illegal codes.
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   en          in   1      sample qualifier; 0 holds all state
//   q_in        in   3      counter output under check
//   expected    out  3      predicted next code
//   locked      out  1      high while LOCKED
//   err         out  1      pulse: mismatch / illegal code while LOCKED
//   illegal     out  1      pulse: sampled code 1 or 4, any state
//   cycle_done  out  1      pulse: correct 2 -> 0 transition while LOCKED
//   err_count   out  ERR_W  saturating count of err pulses
//   cycle_count out  CYC_W  wrapping count of cycle_done pulses
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       q_in,
  output logic [2:0]       expected,
  output logic             locked,
  output logic             err,
  output logic             illegal,
  output logic             cycle_done,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] cycle_count
);

  chk_state_t state;
  logic [2:0] run;
  logic       pred_valid;

  logic       q_legal;
  logic [2:0] q_succ;
  logic       hit;
  logic [2:0] run_nxt;

  seq_next_lut u_lut (
    .q     (q_in),
    .legal (q_legal),
    .succ  (q_succ)
  );

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // In HUNT a match extends the run; anything else re-anchors at 1.
  assign hit     = pred_valid && (q_in == expected);
  assign run_nxt = hit ? run + 3'd1 : 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      run         <= 3'd0;
      pred_valid  <= 1'b0;
      expected    <= S0;
      locked      <= 1'b0;
      err         <= 1'b0;
      illegal     <= 1'b0;
      cycle_done  <= 1'b0;
      err_count   <= '0;
      cycle_count <= '0;
    end else begin
      err        <= 1'b0;
      illegal    <= 1'b0;
      cycle_done <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (!q_legal) begin
              // expected holds, but it is no longer trusted
              illegal    <= 1'b1;
              run        <= 3'd0;
              pred_valid <= 1'b0;
            end else begin
              run        <= run_nxt;
              expected   <= q_succ;
              pred_valid <= 1'b1;
              if (run_nxt == 3'(LOCK_COUNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            // expected is always a legal code here, so an illegal q_in
            // can never match and always lands in the error branch.
            if (q_in == expected) begin
              expected <= q_succ;
              // A matching 0 while LOCKED can only follow a 2.
              if (q_in == S0) begin
                cycle_done  <= 1'b1;
                cycle_count <= cycle_count + CYC_W'(1);
              end
            end else begin
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
              state     <= HUNT;
              locked    <= 1'b0;
              if (q_legal) begin
                run        <= 3'd1;
                expected   <= q_succ;
                pred_valid <= 1'b1;
              end else begin
                illegal    <= 1'b1;
                run        <= 3'd0;
                pred_valid <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
